tdc_result_packer: RTL and testbench
====================================

// Module: tdc_result_packer
// PURPOSE
//   Downstream of the merging stage. Captures each merged TDC word {Coarse, StartEdge, StopEdge}
//   when the merging stage pulses done, buffers it in a small FIFO and serializes it as a framed
//   byte stream (header, data MSB-first, XOR checksum) over a valid/ready byte interface.
//   Its output feeds the UART transmitter. FIFO absorbs bursts while the byte link is busy.
// PARAMETERS
//   DIG_OUT     32  width of merged word (COUNTER_DIG + 2*NUM_DECODE)
//   NBYTES       4  data bytes per frame = ceil(DIG_OUT/8)
//   FIFO_AW      3  FIFO address width; depth = 2**FIFO_AW entries
//   HEADER    8'hA5 frame start byte
// PORTS
//   clk           in   1           system clock; same domain as merging stage
//   rst           in   1           asynchronous reset, active-high
//   done_i        in   1           merging-stage done pulse; data_i valid in this cycle
//   data_i        in   DIG_OUT     merged word {Coarse, StartEdge, StopEdge}
//   byte_o        out  8           serialized byte
//   byte_valid_o  out  1           byte_o valid
//   byte_ready_i  in   1           sink accepts byte_o when high with byte_valid_o
//   fifo_count_o  out  FIFO_AW+1   words currently stored (0..2**FIFO_AW)
//   overflow_o    out  1           sticky: at least one word dropped
//   drop_count_o  out  8           dropped words, saturates at 255
//   clr_ovf_i     in   1           sync clear of overflow_o and drop_count_o
// BEHAVIOUR
//   Reset (async, rst=1): byte_o=0, byte_valid_o=0, fifo_count_o=0, overflow_o=0,
//     drop_count_o=0, FSM=IDLE, FIFO pointers 0, done edge register 0. Frame in progress is
//     abandoned; no partial frame is resumed after reset.
//   Capture: push = done_i & ~done_q (rising edge; done_q is done_i delayed one clk). data_i is
//     written on that same edge. A done_i held high N cycles produces exactly one push.
//   FIFO: synchronous, first-word-fall-through not required. pop occurs when FSM leaves IDLE.
//     push & full & ~pop -> word dropped, overflow_o<=1, drop_count_o+=1 (saturate 255).
//     push & full & pop  -> push accepted (no drop). push & pop when empty -> push stored,
//     pop not performed that cycle (IDLE sees empty). fifo_count_o updates the cycle after.
//   clr_ovf_i: clears overflow_o and drop_count_o next edge; if a drop occurs the same cycle,
//     result is overflow_o=1, drop_count_o=1.
//   Frame: HEADER, then data zero-extended to 8*NBYTES bits, most-significant byte first,
//     then CHK = XOR of the NBYTES data bytes (header excluded). Frame = NBYTES+2 bytes.
//   FSM states:
//     IDLE : byte_valid_o=0. If FIFO non-empty: pop into shift reg, chk<=0, -> HDR.
//     HDR  : byte_o=HEADER, valid=1. On ready: idx<=NBYTES-1, -> DATA.
//     DATA : byte_o=byte[idx], valid=1. On ready: chk^=byte; idx==0 -> CHK else idx-=1.
//     CHK  : byte_o=chk, valid=1. On ready -> IDLE.
//   Handshake: transfer when byte_valid_o & byte_ready_i at posedge clk. While valid & ~ready,
//     byte_o and byte_valid_o hold stable. byte_valid_o never drops mid-frame except on rst.
//   Latency: done_i edge at cycle 0 with empty FIFO and ready tied high -> write at edge 1,
//     IDLE pops at edge 2, header valid in cycle 2, last (CHK) byte transferred at edge
//     NBYTES+4; back-to-back frames have one idle cycle between CHK and next HDR.
//   byte_o and byte_valid_o are registered (no combinational path from byte_ready_i).
// TESTING
//   T1 reset: assert rst mid-DATA -> byte_valid_o=0, fifo_count_o=0 same cycle; no output after.
//   T2 single word: data_i=32'h12345678, done_i pulse, ready=1 -> bytes A5,12,34,56,78,08.
//   T3 backpressure: ready toggles 1/0 each cycle on T2 word -> same 6 bytes, byte_o stable on
//      stalled cycles, no byte duplicated or lost.
//   T4 overflow: ready=0, 10 done pulses (depth 8) -> fifo_count_o=8, overflow_o=1,
//      drop_count_o=2; then ready=1 -> first 8 words out in order; clr_ovf_i -> both 0.
//   T5 done held high 5 cycles -> exactly one push, fifo_count_o=1.
//   T6 push on full with concurrent pop (IDLE leaving with count 8) -> no drop, count stays 8.

Source files
------------

// File: rtl/tdc_result_packer.sv
// ---------------------------------------------------------------------------
// tdc_result_packer
//
// Captures each merged TDC word {Coarse, StartEdge, StopEdge} on the rising
// edge of the merging stage's done pulse. The word is held in a small FIFO
// and sent out as a framed byte stream over a valid/ready byte interface:
//
//     HEADER, data bytes (most significant first), XOR checksum of data bytes
//
// The FIFO absorbs bursts while the byte link (UART transmitter) is busy.
// When the FIFO is full and no word leaves it, an arriving word is dropped
// and counted.
//
// Ports
//   clk           in   1           system clock (same domain as merging stage)
//   rst           in   1           asynchronous reset, active-high
//   done_i        in   1           merging-stage done; data_i valid this cycle
//   data_i        in   DIG_OUT     merged word {Coarse, StartEdge, StopEdge}
//   byte_o        out  8           serialized byte (registered)
//   byte_valid_o  out  1           byte_o valid (registered)
//   byte_ready_i  in   1           sink takes byte_o when high with byte_valid_o
//   fifo_count_o  out  FIFO_AW+1   words currently stored
//   overflow_o    out  1           sticky, at least one word dropped
//   drop_count_o  out  8           dropped words, saturating at 255
//   clr_ovf_i     in   1           synchronous clear of overflow_o/drop_count_o
// ---------------------------------------------------------------------------
module tdc_result_packer #(
    parameter int          DIG_OUT = 32,
    parameter int          NBYTES  = 4,
    parameter int          FIFO_AW = 3,
    parameter logic [7:0]  HEADER  = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 done_i,
    input  logic [DIG_OUT-1:0]   data_i,
    output logic [7:0]           byte_o,
    output logic                 byte_valid_o,
    input  logic                 byte_ready_i,
    output logic [FIFO_AW:0]     fifo_count_o,
    output logic                 overflow_o,
    output logic [7:0]           drop_count_o,
    input  logic                 clr_ovf_i
);

    localparam int FW = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [FIFO_AW:0]   DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE = 1;
    localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
    localparam logic [IW-1:0]      IDX_ONE = 1;
    localparam logic [IW-1:0]      IDX_TOP = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        CHK
    } state_t;

    state_t              state;
    logic                done_q;
    logic [DIG_OUT-1:0]  mem [1 << FIFO_AW];
    logic [FIFO_AW-1:0]  wr_ptr;
    logic [FIFO_AW-1:0]  rd_ptr;
    logic [FW-1:0]       word_q;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       next_idx;
    logic [7:0]          chk;
    logic [7:0]          cur_byte;

    logic push;
    logic pop;
    logic full;
    logic empty;
    logic push_ok;
    logic drop;
    logic xfer;

    // Only the rising edge of done counts, so a done held high for several
    // cycles still stores exactly one word.
    assign push  = done_i & ~done_q;
    assign full  = (fifo_count_o == DEPTH_C);
    assign empty = (fifo_count_o == '0);

    // The serializer pulls a word whenever it sits in IDLE with data waiting.
    // Because the count is registered, a word pushed into an empty FIFO is not
    // visible to IDLE until the following cycle.
    assign pop     = (state == IDLE) & ~empty;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    assign xfer     = byte_valid_o & byte_ready_i;
    assign next_idx = idx - IDX_ONE;
    assign cur_byte = word_q[{idx, 3'b000} +: 8];

    // Delayed copy of done for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_i;
        end
    end

    // FIFO storage has no reset; only the pointers and count define content.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // FIFO pointers and occupancy. A push and a pop in the same cycle leave
    // the count unchanged, which is what lets a full FIFO accept a new word
    // in the cycle the serializer takes one out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count_o <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop) begin
                fifo_count_o <= fifo_count_o + CNT_ONE;
            end else if (!push_ok && pop) begin
                fifo_count_o <= fifo_count_o - CNT_ONE;
            end
        end
    end

    // Drop bookkeeping. A clear that coincides with a drop leaves exactly one
    // drop recorded, so the new loss is never hidden by the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o   <= 1'b0;
            drop_count_o <= 8'd0;
        end else if (clr_ovf_i) begin
            overflow_o   <= drop;
            drop_count_o <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_count_o != 8'hFF) begin
                drop_count_o <= drop_count_o + 8'd1;
            end
        end
    end

    // Frame serializer. byte_o/byte_valid_o are loaded with the next byte at
    // the same edge that accepts the current one, so the outputs stay
    // registered and simply hold while the sink stalls. The checksum byte is
    // formed from the running XOR plus the last data byte at that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            byte_o       <= 8'd0;
            byte_valid_o <= 1'b0;
            word_q       <= '0;
            idx          <= '0;
            chk          <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    byte_valid_o <= 1'b0;
                    if (pop) begin
                        word_q       <= FW'(mem[rd_ptr]);
                        chk          <= 8'd0;
                        byte_o       <= HEADER;
                        byte_valid_o <= 1'b1;
                        state        <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        idx    <= IDX_TOP;
                        byte_o <= word_q[FW-1 -: 8];
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        chk <= chk ^ cur_byte;
                        if (idx == '0) begin
                            byte_o <= chk ^ cur_byte;
                            state  <= CHK;
                        end else begin
                            idx    <= next_idx;
                            byte_o <= word_q[{next_idx, 3'b000} +: 8];
                        end
                    end
                end
                CHK: begin
                    if (xfer) begin
                        byte_o       <= 8'd0;
                        byte_valid_o <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    byte_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_result_packer.sv
// ---------------------------------------------------------------------------
// tb_tdc_result_packer
//
// Self-checking bench for tdc_result_packer. Each test task drives its own
// scenario and compares status outputs inline. Expected frame bytes are
// pushed into a queue when a word is offered to the DUT; a negedge monitor
// pops and compares one entry for every byte handshake and also checks that
// the byte interface holds steady while stalled.
// ---------------------------------------------------------------------------
module tb_tdc_result_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        done_i;
    logic [31:0] data_i;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        byte_ready_i;
    logic [3:0]  fifo_count_o;
    logic        overflow_o;
    logic [7:0]  drop_count_o;
    logic        clr_ovf_i;

    int          vectors     = 0;
    int          miscompares = 0;
    int          xfer_count  = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_exp;
    logic [7:0]  prev_byte;
    logic        prev_stall = 1'b0;

    tdc_result_packer #(
        .DIG_OUT (32),
        .NBYTES  (4),
        .FIFO_AW (3),
        .HEADER  (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .done_i       (done_i),
        .data_i       (data_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .fifo_count_o (fifo_count_o),
        .overflow_o   (overflow_o),
        .drop_count_o (drop_count_o),
        .clr_ovf_i    (clr_ovf_i)
    );

    always #5 clk = ~clk;

    // Byte-stream monitor: inputs change just after posedge, so at negedge a
    // valid & ready pair means the byte is taken at the coming posedge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                vectors++;
                if (byte_valid_o !== 1'b1 || byte_o !== prev_byte) begin
                    miscompares++;
                    $display("[TB] FAIL stall_hold: byte_o=%h valid=%b, expected byte_o=%h valid=1",
                             byte_o, byte_valid_o, prev_byte);
                end
            end
            if (byte_valid_o === 1'b1 && byte_ready_i === 1'b1) begin
                vectors++;
                xfer_count++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_byte: got %h, expected no byte", byte_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (byte_o !== mon_exp) begin
                        miscompares++;
                        $display("[TB] FAIL byte_stream: got %h, expected %h", byte_o, mon_exp);
                    end
                end
            end
            prev_stall = (byte_valid_o === 1'b1) && (byte_ready_i === 1'b0);
            prev_byte  = byte_o;
        end
    end

    // Model of a frame: header, four data bytes MSB first, XOR of data bytes.
    task automatic push_frame(input logic [31:0] w);
        logic [7:0] b;
        logic [7:0] c;
        c = 8'h00;
        exp_q.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) begin
            b = w[8*i +: 8];
            c = c ^ b;
            exp_q.push_back(b);
        end
        exp_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input logic [31:0] w);
        data_i = w;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || byte_valid_o !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0 || byte_valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_timeout: %0d bytes pending valid=%b, expected 0 pending valid=0",
                     name, exp_q.size(), byte_valid_o);
        end
    endtask

    task automatic do_reset();
        done_i       = 1'b0;
        clr_ovf_i    = 1'b0;
        byte_ready_i = 1'b0;
        data_i       = 32'h0;
        rst          = 1'b1;
        tick();
        tick();
        exp_q.delete();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic saw_valid;
        do_reset();
        rst = 1'b1;
        #1;
        vectors += 5;
        if (byte_o !== 8'h00) begin
            miscompares++; $display("[TB] FAIL reset_byte: got %h, expected 00", byte_o);
        end
        if (byte_valid_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_valid: got %b, expected 0", byte_valid_o);
        end
        if (fifo_count_o !== 4'd0) begin
            miscompares++; $display("[TB] FAIL reset_count: got %0d, expected 0", fifo_count_o);
        end
        if (overflow_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_ovf: got %b, expected 0", overflow_o);
        end
        if (drop_count_o !== 8'd0) begin
            miscompares++; $display("[TB] FAIL reset_drops: got %0d, expected 0", drop_count_o);
        end
        tick();
        rst = 1'b0;
        byte_ready_i = 1'b1;
        tick();
        // Word A starts a frame; word B waits in the FIFO; reset lands mid-DATA.
        push_frame(32'hCAFE0123);
        data_i = 32'hCAFE0123;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        tick();
        data_i = 32'h0BADF00D;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        vectors += 2;
        if (byte_valid_o !== 1'b1 || byte_o !== 8'hCA) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_data: byte_o=%h valid=%b, expected CA valid=1", byte_o, byte_valid_o);
        end
        if (fifo_count_o !== 4'd1) begin
            miscompares++; $display("[TB] FAIL pre_reset_count: got %0d, expected 1", fifo_count_o);
        end
        #1;
        rst = 1'b1;
        #1;
        vectors += 2;
        if (byte_valid_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL async_reset_valid: got %b, expected 0", byte_valid_o);
        end
        if (fifo_count_o !== 4'd0) begin
            miscompares++; $display("[TB] FAIL async_reset_count: got %0d, expected 0", fifo_count_o);
        end
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (byte_valid_o !== 1'b0) saw_valid = 1'b1;
        end
        vectors++;
        if (saw_valid) begin
            miscompares++; $display("[TB] FAIL post_reset_idle: got valid=1, expected no output after reset");
        end
    endtask

    task automatic test_single_word();
        do_reset();
        byte_ready_i = 1'b1;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h56);
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h08);
        data_i = 32'h12345678;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        vectors += 2;
        if (byte_valid_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL lat_cycle1_valid: got %b, expected 0", byte_valid_o);
        end
        if (fifo_count_o !== 4'd1) begin
            miscompares++; $display("[TB] FAIL lat_cycle1_count: got %0d, expected 1", fifo_count_o);
        end
        tick();
        vectors += 2;
        if (byte_valid_o !== 1'b1 || byte_o !== 8'hA5) begin
            miscompares++;
            $display("[TB] FAIL lat_header: byte_o=%h valid=%b, expected A5 valid=1", byte_o, byte_valid_o);
        end
        if (fifo_count_o !== 4'd0) begin
            miscompares++; $display("[TB] FAIL lat_pop_count: got %0d, expected 0", fifo_count_o);
        end
        repeat (6) tick();
        vectors++;
        if (byte_valid_o !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL lat_frame_end: valid=%b pending=%0d, expected valid=0 pending=0",
                     byte_valid_o, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        push_frame(32'h12345678);
        data_i = 32'h12345678;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || byte_valid_o !== 1'b0) && n < 60) begin
            byte_ready_i = ~byte_ready_i;
            tick();
            n++;
        end
        byte_ready_i = 1'b1;
        wait_drain(10, "backpressure");
        repeat (5) tick();
    endtask

    task automatic test_overflow();
        do_reset();
        push_frame(32'hC0FFEE00);
        pulse_done(32'hC0FFEE00);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) push_frame(32'hA0000000 | 32'(i));
            pulse_done(32'hA0000000 | 32'(i));
        end
        vectors += 3;
        if (fifo_count_o !== 4'd8) begin
            miscompares++; $display("[TB] FAIL ovf_count: got %0d, expected 8", fifo_count_o);
        end
        if (overflow_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL ovf_flag: got %b, expected 1", overflow_o);
        end
        if (drop_count_o !== 8'd2) begin
            miscompares++; $display("[TB] FAIL ovf_drops: got %0d, expected 2", drop_count_o);
        end
        byte_ready_i = 1'b1;
        wait_drain(200, "overflow_drain");
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        vectors += 2;
        if (overflow_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL clr_flag: got %b, expected 0", overflow_o);
        end
        if (drop_count_o !== 8'd0) begin
            miscompares++; $display("[TB] FAIL clr_drops: got %0d, expected 0", drop_count_o);
        end
    endtask

    task automatic test_drop_saturate();
        do_reset();
        pulse_done(32'h11111111);
        for (int i = 0; i < 268; i++) begin
            pulse_done(32'h22220000 | 32'(i));
        end
        vectors += 2;
        if (drop_count_o !== 8'd255) begin
            miscompares++; $display("[TB] FAIL sat_drops: got %0d, expected 255", drop_count_o);
        end
        if (fifo_count_o !== 4'd8) begin
            miscompares++; $display("[TB] FAIL sat_count: got %0d, expected 8", fifo_count_o);
        end
        // Clear in the same cycle as another drop keeps that drop recorded.
        data_i    = 32'h33333333;
        done_i    = 1'b1;
        clr_ovf_i = 1'b1;
        tick();
        done_i    = 1'b0;
        clr_ovf_i = 1'b0;
        vectors += 2;
        if (overflow_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL clr_drop_flag: got %b, expected 1", overflow_o);
        end
        if (drop_count_o !== 8'd1) begin
            miscompares++; $display("[TB] FAIL clr_drop_count: got %0d, expected 1", drop_count_o);
        end
    endtask

    task automatic test_done_held();
        do_reset();
        push_frame(32'h44556677);
        pulse_done(32'h44556677);
        push_frame(32'h8899AABB);
        data_i = 32'h8899AABB;
        done_i = 1'b1;
        repeat (5) tick();
        done_i = 1'b0;
        tick();
        vectors++;
        if (fifo_count_o !== 4'd1) begin
            miscompares++; $display("[TB] FAIL held_count: got %0d, expected 1", fifo_count_o);
        end
        byte_ready_i = 1'b1;
        wait_drain(40, "held_drain");
    endtask

    task automatic test_full_with_pop();
        int n;
        int n0;
        do_reset();
        push_frame(32'h5A5A0000);
        pulse_done(32'h5A5A0000);
        for (int i = 0; i < 8; i++) begin
            push_frame(32'h60000000 | 32'(i));
            pulse_done(32'h60000000 | 32'(i));
        end
        n0 = xfer_count;
        byte_ready_i = 1'b1;
        n = 0;
        @(negedge clk);
        #1;
        while (xfer_count < n0 + 6 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        vectors++;
        if (xfer_count < n0 + 6) begin
            miscompares++;
            $display("[TB] FAIL full_pop_wait: got %0d bytes, expected 6", xfer_count - n0);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (byte_valid_o !== 1'b0 || fifo_count_o !== 4'd8) begin
            miscompares++;
            $display("[TB] FAIL full_pop_idle: valid=%b count=%0d, expected valid=0 count=8",
                     byte_valid_o, fifo_count_o);
        end
        push_frame(32'h77777777);
        data_i = 32'h77777777;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        vectors += 3;
        if (fifo_count_o !== 4'd8) begin
            miscompares++; $display("[TB] FAIL full_pop_count: got %0d, expected 8", fifo_count_o);
        end
        if (overflow_o !== 1'b0 || drop_count_o !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL full_pop_drop: ovf=%b drops=%0d, expected ovf=0 drops=0",
                     overflow_o, drop_count_o);
        end
        if (byte_valid_o !== 1'b1 || byte_o !== 8'hA5) begin
            miscompares++;
            $display("[TB] FAIL full_pop_header: byte_o=%h valid=%b, expected A5 valid=1", byte_o, byte_valid_o);
        end
        wait_drain(200, "full_pop_drain");
    endtask

    initial begin
        rst          = 1'b0;
        done_i       = 1'b0;
        data_i       = 32'h0;
        byte_ready_i = 1'b0;
        clr_ovf_i    = 1'b0;
        #2;
        test_reset();
        test_single_word();
        test_backpressure();
        test_overflow();
        test_drop_saturate();
        test_done_held();
        test_full_with_pop();
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
